// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target answering one 7-bit address on an oversampled SCL/SDA bus.
//   A write loads the register pointer from its first data byte and emits
//   every later byte as a one-clock write strobe at the current pointer.
//   A read returns bytes from the register port starting at the pointer.
//   No clock stretching; the system clock must be >= 20x SCL.
// Ports
//   I_Clk_in    system clock
//   I_Rst       asynchronous active-high reset
//   I_SCL       bus clock from the master
//   IO_SDA      bus data, only ever pulled low or released
//   O_Reg_Addr  register pointer / register-port address
//   O_Wr_En     one-clock write strobe
//   O_Wr_Data   write data, valid while O_Wr_En is high
//   I_Rd_Data   read data for O_Reg_Addr
//   O_Busy      high from address match until STOP or abort
//   O_Addr_Hit  one-clock pulse on address match
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic       I_Clk_in,
  input  logic       I_Rst,
  input  logic       I_SCL,
  inout  wire        IO_SDA,
  output logic [7:0] O_Reg_Addr,
  output logic       O_Wr_En,
  output logic [7:0] O_Wr_Data,
  input  logic [7:0] I_Rd_Data,
  output logic       O_Busy,
  output logic       O_Addr_Hit
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FMAX = FCW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_RX_PTR, S_ACK_PTR, S_RX_DATA, S_ACK_DATA,
    S_TX, S_TX_ACK, S_TX_LOAD, S_WAIT_STOP, S_IGNORE
  } state_t;

  // Bit 1 = SCL, bit 0 = SDA throughout the input path.
  logic [1:0]     raw, sync_p0, sync_p1, filt, filt_d;
  logic [FCW-1:0] fcnt [2];

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [7:0] reg_addr_nx, wr_data_nx;
  logic       wr_en_nx, busy_nx, hit_nx, rw, rw_nx;
  logic       sda_low, sda_low_nx;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c, bit_in;

  assign raw    = {I_SCL, IO_SDA};
  // The drive flop is asynchronously reset, so reset releases the bus at once.
  assign IO_SDA = sda_low ? 1'b0 : 1'bz;

  // ---- Stage p0/p1: synchronizer, then glitch filter on the synchronized level
  always_ff @(posedge I_Clk_in or posedge I_Rst) begin
    if (I_Rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      filt_d  <= filt;
      for (int i = 0; i < 2; i++) begin
        // The filtered level follows only after FILTER_LEN equal differing samples.
        if (sync_p1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= sync_p1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise = filt[1] & ~filt_d[1];
  assign scl_fall = ~filt[1] & filt_d[1];
  assign sda_rise = filt[0] & ~filt_d[0];
  assign sda_fall = ~filt[0] & filt_d[0];
  assign start_c  = sda_fall & filt[1];
  assign stop_c   = sda_rise & filt[1];
  assign bit_in   = filt[0];

  // ---- Stage p2: protocol FSM on filtered edge events
  always_ff @(posedge I_Clk_in or posedge I_Rst) begin
    if (I_Rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      sda_low    <= 1'b0;
      O_Reg_Addr <= '0;
      O_Wr_En    <= 1'b0;
      O_Wr_Data  <= '0;
      O_Busy     <= 1'b0;
      O_Addr_Hit <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      rw         <= rw_nx;
      sda_low    <= sda_low_nx;
      O_Reg_Addr <= reg_addr_nx;
      O_Wr_En    <= wr_en_nx;
      O_Wr_Data  <= wr_data_nx;
      O_Busy     <= busy_nx;
      O_Addr_Hit <= hit_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shreg_nx    = shreg;
    rw_nx       = rw;
    sda_low_nx  = sda_low;
    reg_addr_nx = O_Reg_Addr;
    wr_en_nx    = 1'b0;
    wr_data_nx  = O_Wr_Data;
    busy_nx     = O_Busy;
    hit_nx      = 1'b0;

    // STOP outranks everything; a bit event in the same cycle is dropped.
    if (stop_c) begin
      state_nx   = S_IDLE;
      sda_low_nx = 1'b0;
      busy_nx    = 1'b0;
      cnt_nx     = '0;
    end else if (start_c) begin
      state_nx   = S_ADDR;
      sda_low_nx = 1'b0;
      cnt_nx     = '0;
    end else begin
      case (state)
        S_ADDR, S_RX_PTR, S_RX_DATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_nx = {shreg[6:0], bit_in};
            cnt_nx   = cnt + 4'd1;
            // Data bytes are written as soon as the last bit is sampled.
            if (state == S_RX_DATA && cnt == 4'd7) begin
              wr_data_nx = {shreg[6:0], bit_in};
              wr_en_nx   = 1'b1;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            if (state == S_ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                sda_low_nx = 1'b1;
                hit_nx     = 1'b1;
                busy_nx    = 1'b1;
                rw_nx      = shreg[0];
                state_nx   = S_ACK_A;
              end else begin
                busy_nx  = 1'b0;
                state_nx = S_IGNORE;
              end
            end else begin
              sda_low_nx = 1'b1;
              if (state == S_RX_PTR) begin
                reg_addr_nx = shreg;
                state_nx    = S_ACK_PTR;
              end else begin
                state_nx = S_ACK_DATA;
              end
            end
          end
        end
        S_ACK_A, S_TX_LOAD: begin
          if (scl_fall) begin
            if (state == S_TX_LOAD || rw) begin
              shreg_nx   = I_Rd_Data;
              sda_low_nx = ~I_Rd_Data[7];
              cnt_nx     = 4'd1;
              state_nx   = S_TX;
            end else begin
              sda_low_nx = 1'b0;
              cnt_nx     = '0;
              state_nx   = S_RX_PTR;
            end
          end
        end
        S_ACK_PTR, S_ACK_DATA: begin
          if (scl_fall) begin
            sda_low_nx = 1'b0;
            cnt_nx     = '0;
            state_nx   = S_RX_DATA;
            if (state == S_ACK_DATA) reg_addr_nx = O_Reg_Addr + 8'd1;
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_low_nx = 1'b0;
              state_nx   = S_TX_ACK;
            end else begin
              sda_low_nx = ~shreg[6];
              shreg_nx   = {shreg[6:0], 1'b0};
              cnt_nx     = cnt + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          // The pointer advances on ACK and NACK alike.
          if (scl_rise) begin
            reg_addr_nx = O_Reg_Addr + 8'd1;
            state_nx    = bit_in ? S_WAIT_STOP : S_TX_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder
//   Bus-level bench: drives SCL/SDA as a master, models the register read
//   port as addr^0xFF, and scoreboards writes and read bytes against
//   expectations queued when each transfer is issued.
module tb_i2c_slave_responder;

  localparam int T_Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, busy, addr_hit;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .I_Clk_in   (clk),
    .I_Rst      (rst),
    .I_SCL      (scl),
    .IO_SDA     (sda),
    .O_Reg_Addr (reg_addr),
    .O_Wr_En    (wr_en),
    .O_Wr_Data  (wr_data),
    .I_Rd_Data  (rd_data),
    .O_Busy     (busy),
    .O_Addr_Hit (addr_hit)
  );

  // Register port model: data follows the address one clock later.
  always @(posedge clk) rd_data <= reg_addr ^ 8'hFF;

  int n_tests = 0;
  int n_fail  = 0;
  int hit_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [15:0] e_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (addr_hit === 1'b1) hit_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (sda === 1'b0 && !m_low) low_cnt++;
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        e_wr = exp_wr.pop_front();
        chk("wr_addr_data", {16'd0, reg_addr, wr_data}, {16'd0, e_wr});
      end
    end
  end

  task automatic q();
    repeat (T_Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q(); scl = 1'b1; q(); m_low = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q(); scl = 1'b1; q(); m_low = 1'b0; q();
  endtask

  // Glitch mode adds a 1-clock SCL pulse in each low phase and a 1-clock
  // opposite-level pulse (SCL low or SDA low) in each high phase.
  task automatic send_bits(input logic [7:0] b, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      if (glitch) begin
        repeat (4) @(negedge clk); scl = 1'b1;
        @(negedge clk); scl = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        q();
      end
      scl = 1'b1;
      if (glitch) begin
        repeat (5) @(negedge clk);
        if (b[i]) begin m_low = 1'b1; @(negedge clk); m_low = 1'b0; end
        else begin scl = 1'b0; @(negedge clk); scl = 1'b1; end
        repeat (14) @(negedge clk);
      end else begin
        q(); q();
      end
      scl = 1'b0; q();
    end
  endtask

  task automatic get_ack(output logic ack);
    m_low = 1'b0; q(); scl = 1'b1; q(); ack = sda; q(); scl = 1'b0; q();
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b, input bit glitch, input logic exp_ack);
    logic ack;
    send_bits(b, glitch);
    get_ack(ack);
    chk(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic rd_byte(input bit nack);
    logic [7:0] b;
    logic [7:0] e;
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      q(); scl = 1'b1; q(); b[i] = sda; q(); scl = 1'b0;
    end
    q(); m_low = ~nack; q(); scl = 1'b1; q(); q(); scl = 1'b0; q(); m_low = 1'b0;
    if (exp_rd.size() == 0) begin
      chk("rd_unexpected", 32'(exp_rd.size()), 32'd1);
    end else begin
      e = exp_rd.pop_front();
      chk("rd_byte", 32'(b), 32'(e));
    end
  endtask

  int h0, l0, b0;

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_outs", {reg_addr, wr_data, 5'd0, wr_en, busy, addr_hit}, 32'd0);

    // T1: pointer write then two data writes
    h0 = hit_cnt;
    i2c_start();
    wr_byte("t1_ack_addr", 8'h78, 1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wr_byte("t1_ack_ptr", 8'h10, 1'b0, 1'b0);
    exp_wr.push_back({8'h10, 8'hA5});
    wr_byte("t1_ack_d0", 8'hA5, 1'b0, 1'b0);
    exp_wr.push_back({8'h11, 8'h5A});
    wr_byte("t1_ack_d1", 8'h5A, 1'b0, 1'b0);
    i2c_stop();
    q();
    chk("t1_ptr", 32'(reg_addr), 32'h12);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_hits", hit_cnt - h0, 32'd1);

    // T2: pointer write, repeated start, three reads
    h0 = hit_cnt;
    i2c_start();
    wr_byte("t2_ack_addr", 8'h78, 1'b0, 1'b0);
    wr_byte("t2_ack_ptr", 8'h20, 1'b0, 1'b0);
    i2c_start();
    wr_byte("t2_ack_raddr", 8'h79, 1'b0, 1'b0);
    exp_rd.push_back(8'hDF); rd_byte(1'b0);
    exp_rd.push_back(8'hDE); rd_byte(1'b0);
    exp_rd.push_back(8'hDD); rd_byte(1'b1);
    i2c_stop();
    q();
    chk("t2_ptr", 32'(reg_addr), 32'h23);
    chk("t2_hits", hit_cnt - h0, 32'd2);

    // T3: wrong address is never acknowledged
    h0 = hit_cnt; l0 = low_cnt; b0 = busy_cnt;
    i2c_start();
    wr_byte("t3_nack_addr", 8'h7A, 1'b0, 1'b1);
    wr_byte("t3_nack_data", 8'h11, 1'b0, 1'b1);
    i2c_stop();
    q();
    chk("t3_sda_low", low_cnt - l0, 32'd0);
    chk("t3_hits", hit_cnt - h0, 32'd0);
    chk("t3_busy", busy_cnt - b0, 32'd0);
    chk("t3_ptr", 32'(reg_addr), 32'h23);

    // T4: pointer wrap
    i2c_start();
    wr_byte("t4_ack_addr", 8'h78, 1'b0, 1'b0);
    wr_byte("t4_ack_ptr", 8'hFF, 1'b0, 1'b0);
    exp_wr.push_back({8'hFF, 8'h01});
    wr_byte("t4_ack_d0", 8'h01, 1'b0, 1'b0);
    exp_wr.push_back({8'h00, 8'h02});
    wr_byte("t4_ack_d1", 8'h02, 1'b0, 1'b0);
    i2c_stop();
    q();
    chk("t4_ptr", 32'(reg_addr), 32'h01);

    // T5: glitches on SCL and SDA are filtered out
    i2c_start();
    wr_byte("t5_ack_addr", 8'h78, 1'b0, 1'b0);
    wr_byte("t5_ack_ptr", 8'h40, 1'b1, 1'b0);
    exp_wr.push_back({8'h40, 8'h3C});
    wr_byte("t5_ack_d0", 8'h3C, 1'b1, 1'b0);
    i2c_stop();
    q();
    chk("t5_ptr", 32'(reg_addr), 32'h41);

    // T6: reset while the slave holds ACK low
    i2c_start();
    send_bits(8'h78, 1'b0);
    m_low = 1'b0; q();
    chk("t6_ack_driven", 32'(sda), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("t6_sda_released", 32'(sda), 32'd1);
    chk("t6_outs", {reg_addr, wr_data, 5'd0, wr_en, busy, addr_hit}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q();
    h0 = hit_cnt;
    i2c_start();
    wr_byte("t6_ack_addr", 8'h78, 1'b0, 1'b0);
    wr_byte("t6_ack_ptr", 8'h05, 1'b0, 1'b0);
    i2c_stop();
    q();
    chk("t6_ptr", 32'(reg_addr), 32'h05);
    chk("t6_hits", hit_cnt - h0, 32'd1);

    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
